// File: rtl/riscv_dmem_responder.sv
// Data-side memory responder for the RV32I core: word RAM with byte-lane stores,
// extended loads, and a 16-byte MMIO window with timer, interrupt and fault capture.
`timescale 1ns/1ps
module riscv_dmem_responder #(
    parameter int unsigned DMEM_DEPTH = 1024,
    parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
    localparam int unsigned XLEN      = 32
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic [XLEN-1:0] i_dmem_addr,
    input  logic [XLEN-1:0] i_dmem_wr_data,
    input  logic            i_dmem_wr_en,
    input  logic            i_dmem_rd_en,
    input  logic [3:0]      i_dmem_byte_sel,
    input  logic [2:0]      i_dmem_func3,
    output logic [XLEN-1:0] o_dmem_rd_data,
    output logic            o_dmem_irq,
    output logic            o_dmem_fault,
    output logic [XLEN-1:0] o_dmem_fault_addr
);

    localparam int unsigned AW        = $clog2(DMEM_DEPTH);
    localparam int unsigned RAM_BYTES = 4 * DMEM_DEPTH;

    logic [XLEN-1:0] r_mem [DMEM_DEPTH];
    logic [XLEN-1:0] r_mtime;
    logic [XLEN-1:0] r_mtimecmp;
    logic            r_irq_pend;
    logic            r_fault;
    logic [XLEN-1:0] r_fault_addr;

    logic            w_ram_hit;
    logic            w_mmio_hit;
    logic            w_access;
    logic            w_misalign;
    logic            w_ram_wr;
    logic            w_mmio_wr;
    logic [1:0]      w_reg_sel;
    logic [1:0]      w_size;
    logic [AW-1:0]   w_idx;
    logic [3:0]      w_lane;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_word;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_mmio_rdata;
    logic [XLEN-1:0] w_rd_data;
    logic            w_clr_irq;
    logic            w_clr_fault;

    assign w_ram_hit  = i_dmem_addr < XLEN'(RAM_BYTES);
    assign w_mmio_hit = i_dmem_addr[31:4] == MMIO_BASE[31:4];
    assign w_access   = i_dmem_rd_en | i_dmem_wr_en;
    assign w_size     = i_dmem_func3[1:0];
    assign w_reg_sel  = i_dmem_addr[3:2];
    assign w_idx      = i_dmem_addr[AW+1:2];

    // Unmapped addresses never fault; MMIO only accepts word accesses
    always_comb begin
        w_misalign = 1'b0;
        if (w_access && (w_ram_hit || w_mmio_hit)) begin
            if (w_size == 2'b01 && i_dmem_addr[0])
                w_misalign = 1'b1;
            if (w_size == 2'b10 && i_dmem_addr[1:0] != 2'b00)
                w_misalign = 1'b1;
            if (w_mmio_hit && w_size != 2'b10)
                w_misalign = 1'b1;
        end
    end

    assign w_ram_wr    = i_dmem_wr_en & w_ram_hit & ~w_misalign;
    assign w_mmio_wr   = i_dmem_wr_en & w_mmio_hit & ~w_misalign;
    assign w_lane      = 4'(i_dmem_byte_sel << i_dmem_addr[1:0]);
    assign w_wdata     = i_dmem_wr_data << {i_dmem_addr[1:0], 3'b000};
    assign w_clr_irq   = w_mmio_wr && w_reg_sel == 2'd2 && i_dmem_wr_data[0];
    assign w_clr_fault = w_mmio_wr && w_reg_sel == 2'd2 && i_dmem_wr_data[1];

    // RAM is not reset; a store coinciding with reset is dropped
    always_ff @(posedge i_clk) begin
        if (i_rstn && w_ram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (w_lane[b])
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
    end

    assign w_word = r_mem[w_idx];

    always_comb begin
        unique case (i_dmem_addr[1:0])
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
        w_half = i_dmem_addr[1] ? w_word[31:16] : w_word[15:0];
    end

    always_comb begin
        unique case (w_reg_sel)
            2'd0:    w_mmio_rdata = r_mtime;
            2'd1:    w_mmio_rdata = r_mtimecmp;
            2'd2:    w_mmio_rdata = XLEN'({r_fault, r_irq_pend});
            default: w_mmio_rdata = r_fault_addr;
        endcase
    end

    // Loads see pre-edge contents, giving read-before-write on collisions
    always_comb begin
        w_rd_data = '0;
        if (i_dmem_rd_en && !w_misalign) begin
            if (w_ram_hit) begin
                unique case (i_dmem_func3)
                    3'b000:  w_rd_data = {{24{w_byte[7]}}, w_byte};
                    3'b001:  w_rd_data = {{16{w_half[15]}}, w_half};
                    3'b010:  w_rd_data = w_word;
                    3'b100:  w_rd_data = {24'd0, w_byte};
                    3'b101:  w_rd_data = {16'd0, w_half};
                    default: w_rd_data = '0;
                endcase
            end else if (w_mmio_hit) begin
                w_rd_data = w_mmio_rdata;
            end
        end
    end

    // Timer, compare, sticky interrupt and first-fault capture
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_mtime      <= '0;
            r_mtimecmp   <= '1;
            r_irq_pend   <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_addr <= '0;
        end else begin
            if (w_mmio_wr && w_reg_sel == 2'd0)
                r_mtime <= i_dmem_wr_data;
            else
                r_mtime <= r_mtime + XLEN'(1);
            if (w_mmio_wr && w_reg_sel == 2'd1)
                r_mtimecmp <= i_dmem_wr_data;
            r_irq_pend <= (r_mtime == r_mtimecmp) | (r_irq_pend & ~w_clr_irq);
            r_fault    <= w_misalign | (r_fault & ~w_clr_fault);
            if (w_misalign && !r_fault)
                r_fault_addr <= i_dmem_addr;
        end
    end

    assign o_dmem_rd_data    = w_rd_data;
    assign o_dmem_irq        = r_irq_pend;
    assign o_dmem_fault      = r_fault;
    assign o_dmem_fault_addr = r_fault_addr;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Directed self-checking bench for riscv_dmem_responder.
`timescale 1ns/1ps
module tb_riscv_dmem_responder;

    localparam logic [31:0] MB = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [3:0]  bsel;
    logic [2:0]  f3;
    logic [31:0] rdata;
    logic        irq;
    logic        fault;
    logic [31:0] fault_addr;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    riscv_dmem_responder dut (
        .i_clk            (clk),
        .i_rstn           (rstn),
        .i_dmem_addr      (addr),
        .i_dmem_wr_data   (wdata),
        .i_dmem_wr_en     (we),
        .i_dmem_rd_en     (re),
        .i_dmem_byte_sel  (bsel),
        .i_dmem_func3     (f3),
        .o_dmem_rd_data   (rdata),
        .o_dmem_irq       (irq),
        .o_dmem_fault     (fault),
        .o_dmem_fault_addr(fault_addr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic idle();
        addr = '0; wdata = '0; we = 1'b0; re = 1'b0; bsel = 4'b0000; f3 = 3'b000;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] bs, input logic [2:0] fn);
        addr = a; wdata = d; we = 1'b1; re = 1'b0; bsel = bs; f3 = fn;
        tick();
        idle();
    endtask

    // Drives a load for one cycle, samples the combinational result before the edge
    task automatic load(input logic [31:0] a, input logic [2:0] fn, output logic [31:0] d);
        addr = a; wdata = '0; we = 1'b0; re = 1'b1; bsel = 4'b0000; f3 = fn;
        #1;
        d = rdata;
        tick();
        idle();
    endtask

    initial begin
        logic [31:0] d;
        rstn = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;

        check("rst_irq", 32'(irq), 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        check("rst_fault_addr", fault_addr, 32'h0);
        load(MB, 3'b010, d);        check("rst_mtime", d, 32'h0);
        load(MB + 4, 3'b010, d);    check("rst_mtimecmp", d, 32'hFFFF_FFFF);

        // Load extension on one stored word
        store(32'h10, 32'h8000_00F1, 4'b1111, 3'b010);
        load(32'h10, 3'b000, d);    check("lb_10", d, 32'hFFFF_FFF1);
        load(32'h10, 3'b100, d);    check("lbu_10", d, 32'h0000_00F1);
        load(32'h12, 3'b001, d);    check("lh_12", d, 32'hFFFF_8000);
        load(32'h12, 3'b101, d);    check("lhu_12", d, 32'h0000_8000);
        load(32'h10, 3'b010, d);    check("lw_10", d, 32'h8000_00F1);
        load(32'h13, 3'b000, d);    check("lb_13", d, 32'hFFFF_FF80);
        load(32'h11, 3'b100, d);    check("lbu_11", d, 32'h0000_0000);
        load(32'h10, 3'b011, d);    check("f3_011_zero", d, 32'h0);
        check("f3_011_nofault", 32'(fault), 32'h0);

        // rd_en low forces zero
        addr = 32'h10; f3 = 3'b010; re = 1'b0;
        #1;
        check("rd_en_low", rdata, 32'h0);
        tick();
        idle();

        // Read-before-write on a colliding load/store
        addr = 32'h10; wdata = 32'h0000_0055; we = 1'b1; re = 1'b1; bsel = 4'b1111; f3 = 3'b010;
        #1;
        check("rbw_old", rdata, 32'h8000_00F1);
        tick();
        idle();
        load(32'h10, 3'b010, d);    check("rbw_new", d, 32'h0000_0055);

        // Byte and halfword lane stores
        store(32'h20, 32'h0, 4'b1111, 3'b010);
        store(32'h23, 32'h0000_00AB, 4'b0001, 3'b000);
        store(32'h20, 32'h0000_1234, 4'b0011, 3'b001);
        load(32'h20, 3'b010, d);    check("lw_20_lanes", d, 32'hAB00_1234);

        // Misaligned word load, then a second fault must not overwrite the address
        store(32'h04, 32'hCAFE_F00D, 4'b1111, 3'b010);
        load(32'h22, 3'b010, d);    check("lw_22_zero", d, 32'h0);
        check("fault_set", 32'(fault), 32'h1);
        check("fault_addr_22", fault_addr, 32'h22);
        store(32'h05, 32'h0000_FFFF, 4'b0011, 3'b001);
        check("fault_addr_keep", fault_addr, 32'h22);
        load(32'h04, 3'b010, d);    check("sh_05_suppressed", d, 32'hCAFE_F00D);
        load(MB + 8, 3'b010, d);    check("status_fault", d, 32'h2);
        store(MB + 8, 32'h2, 4'b1111, 3'b010);
        check("fault_w1c", 32'(fault), 32'h0);

        // Timer wrap and compare interrupt
        store(MB, 32'hFFFF_FFFE, 4'b1111, 3'b010);
        store(MB + 4, 32'h0000_0001, 4'b1111, 3'b010);
        load(MB, 3'b010, d);        check("mtime_ff", d, 32'hFFFF_FFFF);
        load(MB, 3'b010, d);        check("mtime_wrap", d, 32'h0);
        check("irq_before", 32'(irq), 32'h0);
        load(MB, 3'b010, d);        check("mtime_one", d, 32'h1);
        check("irq_rise", 32'(irq), 32'h1);
        load(MB + 8, 3'b010, d);    check("status_irq", d, 32'h1);
        store(MB + 8, 32'h1, 4'b1111, 3'b010);
        check("irq_w1c", 32'(irq), 32'h0);
        repeat (3) tick();
        check("irq_stays_low", 32'(irq), 32'h0);

        // Unmapped space and non-word MMIO access
        load(32'h2000_0000, 3'b010, d);   check("unmapped_rd", d, 32'h0);
        load(32'h2000_0002, 3'b010, d);   check("unmapped_misalign_rd", d, 32'h0);
        store(32'h2000_0000, 32'h1234_5678, 4'b1111, 3'b010);
        check("unmapped_nofault", 32'(fault), 32'h0);
        store(MB + 4, 32'h0000_0077, 4'b0001, 3'b000);
        check("mmio_sb_fault", 32'(fault), 32'h1);
        check("mmio_sb_addr", fault_addr, MB + 4);
        load(MB + 4, 3'b010, d);    check("mtimecmp_kept", d, 32'h1);
        load(MB + 12, 3'b010, d);   check("fault_addr_reg", d, MB + 4);

        // Reset pulse coinciding with a store
        store(32'h30, 32'h1111_1111, 4'b1111, 3'b010);
        addr = 32'h30; wdata = 32'hDEAD_BEEF; we = 1'b1; re = 1'b0; bsel = 4'b1111; f3 = 3'b010;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        idle();
        check("mid_rst_irq", 32'(irq), 32'h0);
        check("mid_rst_fault", 32'(fault), 32'h0);
        check("mid_rst_fault_addr", fault_addr, 32'h0);
        load(MB, 3'b010, d);        check("mid_rst_mtime", d, 32'h0);
        load(MB + 4, 3'b010, d);    check("mid_rst_mtimecmp", d, 32'hFFFF_FFFF);
        load(32'h30, 3'b010, d);    check("mid_rst_store_dropped", d, 32'h1111_1111);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
